morse_keyer_decoder: RTL and testbench

MORSE_KEYER_DECODER -- requirements
Module: morse_keyer_decoder

---
 rtl/morse_pkg.sv | 25 ++
 rtl/morse_lut.sv | 60 ++++++
 rtl/morse_keyer_decoder.sv | 189 ++++++++++++++++++
 tb/tb_morse_keyer_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer/decoder.
// Contents: assembler FSM state encoding, symbol encoding,
// the ASCII fallback character and the data-path widths.
package morse_pkg;

  localparam int CHAR_W = 8;  // ASCII character width
  localparam int CODE_W = 5;  // symbol shift register width
  localparam int LEN_W  = 3;  // symbol count width
  localparam int DUR_W  = 10; // mark duration counter width

  localparam logic [DUR_W-1:0]  DUR_MAX = 10'd1023;
  localparam logic [LEN_W-1:0]  MAX_LEN = 3'd5;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam logic [CHAR_W-1:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational ITU Morse lookup.
// Ports:
//   length [2:0] : number of symbols received (1..5 meaningful)
//   code   [4:0] : symbols, newest at LSB, dot = 0, dash = 1
//   ascii  [7:0] : 'A'-'Z', '0'-'9', or '?' for any unmapped pattern
// Bits of code above length are expected to be zero, which holds because
// the assembler shifts into a cleared register.
module morse_lut
  import morse_pkg::*;
(
  input  logic [LEN_W-1:0]  length,
  input  logic [CODE_W-1:0] code,
  output logic [CHAR_W-1:0] ascii
);

  // Pattern lookup keyed on {length, code}.
  always_comb begin
    ascii = ASCII_QMARK;
    case ({length, code})
      {3'd1, 5'b00000}: ascii = 8'h45; // E .
      {3'd1, 5'b00001}: ascii = 8'h54; // T -
      {3'd2, 5'b00000}: ascii = 8'h49; // I ..
      {3'd2, 5'b00001}: ascii = 8'h41; // A .-
      {3'd2, 5'b00010}: ascii = 8'h4E; // N -.
      {3'd2, 5'b00011}: ascii = 8'h4D; // M --
      {3'd3, 5'b00000}: ascii = 8'h53; // S
      {3'd3, 5'b00001}: ascii = 8'h55; // U
      {3'd3, 5'b00010}: ascii = 8'h52; // R
      {3'd3, 5'b00011}: ascii = 8'h57; // W
      {3'd3, 5'b00100}: ascii = 8'h44; // D
      {3'd3, 5'b00101}: ascii = 8'h4B; // K
      {3'd3, 5'b00110}: ascii = 8'h47; // G
      {3'd3, 5'b00111}: ascii = 8'h4F; // O
      {3'd4, 5'b00000}: ascii = 8'h48; // H
      {3'd4, 5'b00001}: ascii = 8'h56; // V
      {3'd4, 5'b00010}: ascii = 8'h46; // F
      {3'd4, 5'b00100}: ascii = 8'h4C; // L
      {3'd4, 5'b00110}: ascii = 8'h50; // P
      {3'd4, 5'b00111}: ascii = 8'h4A; // J
      {3'd4, 5'b01000}: ascii = 8'h42; // B
      {3'd4, 5'b01001}: ascii = 8'h58; // X
      {3'd4, 5'b01010}: ascii = 8'h43; // C
      {3'd4, 5'b01011}: ascii = 8'h59; // Y
      {3'd4, 5'b01100}: ascii = 8'h5A; // Z
      {3'd4, 5'b01101}: ascii = 8'h51; // Q
      {3'd5, 5'b11111}: ascii = 8'h30; // 0
      {3'd5, 5'b01111}: ascii = 8'h31; // 1
      {3'd5, 5'b00111}: ascii = 8'h32; // 2
      {3'd5, 5'b00011}: ascii = 8'h33; // 3
      {3'd5, 5'b00001}: ascii = 8'h34; // 4
      {3'd5, 5'b00000}: ascii = 8'h35; // 5
      {3'd5, 5'b10000}: ascii = 8'h36; // 6
      {3'd5, 5'b11000}: ascii = 8'h37; // 7
      {3'd5, 5'b11100}: ascii = 8'h38; // 8
      {3'd5, 5'b11110}: ascii = 8'h39; // 9
      default:          ascii = ASCII_QMARK;
    endcase
  end

endmodule

// File: rtl/morse_keyer_decoder.sv
// Morse key decoder: synchronizes and debounces a raw key, times marks and
// spaces in ticks, assembles dot/dash symbols into a letter and hands the
// ASCII result to a downstream store through a valid/ready hold register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   button_in   : raw key, high = pressed
//   char_ready  : downstream accepts char_data
//   char_data   : decoded ASCII letter
//   char_valid  : char_data holds an unaccepted character
//   key_level   : debounced key level
//   overflow    : sticky, a letter was dropped while the store was full
module morse_keyer_decoder
  import morse_pkg::*;
#(
  parameter int TICK_CYC         = 50000,
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int DOT_MAX_TICKS    = 200,
  parameter int LETTER_GAP_TICKS = 600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button_in,
  input  logic              char_ready,
  output logic [CHAR_W-1:0] char_data,
  output logic              char_valid,
  output logic              key_level,
  output logic              overflow
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int TICK_W = $clog2(TICK_CYC + 1);
  localparam int GAP_W  = $clog2(LETTER_GAP_TICKS + 1);

  logic              sync1_r, sync2_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic              key_level_r, key_d_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_r;
  state_t            state_r;
  logic [DUR_W-1:0]  dur_r;
  logic [GAP_W-1:0]  gap_r;
  logic [CODE_W-1:0] code_r;
  logic [LEN_W-1:0]  len_r;
  logic              too_long_r;
  logic              letter_done_r;
  logic [CHAR_W-1:0] done_char_r;
  logic [CHAR_W-1:0] char_data_r;
  logic              char_valid_r;
  logic              overflow_r;
  logic              rise_s, fall_s, symbol_s;
  logic [CHAR_W-1:0] lut_ascii_s;

  assign rise_s   = key_level_r & ~key_d_r;
  assign fall_s   = ~key_level_r & key_d_r;
  assign symbol_s = (dur_r >= DUR_W'(DOT_MAX_TICKS)) ? SYM_DASH : SYM_DOT;

  morse_lut u_lut (
    .length (len_r),
    .code   (code_r),
    .ascii  (lut_ascii_s)
  );

  // Two-flop synchronizer for the raw key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= button_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_r   <= '0;
      key_level_r <= 1'b0;
      key_d_r     <= 1'b0;
    end else begin
      key_d_r <= key_level_r;
      if (sync2_r != key_level_r) begin
        if (deb_cnt_r == DEB_W'(DEBOUNCE_CYC - 1)) begin
          key_level_r <= sync2_r;
          deb_cnt_r   <= '0;
        end else begin
          deb_cnt_r <= deb_cnt_r + DEB_W'(1);
        end
      end else begin
        deb_cnt_r <= '0;
      end
    end
  end

  // Free-running prescaler producing a one-clock timing tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b0;
    end else if (tick_cnt_r == TICK_W'(TICK_CYC - 1)) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      tick_r     <= 1'b0;
    end
  end

  // Letter assembler FSM. The finished character is captured together with
  // letter_done because code/length clear in that same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      dur_r         <= '0;
      gap_r         <= '0;
      code_r        <= '0;
      len_r         <= '0;
      too_long_r    <= 1'b0;
      letter_done_r <= 1'b0;
      done_char_r   <= '0;
    end else begin
      letter_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r <= ST_MARK;
            dur_r   <= '0;
          end
        end
        ST_MARK: begin
          if (fall_s) begin
            state_r <= ST_SPACE;
            gap_r   <= '0;
            code_r  <= {code_r[CODE_W-2:0], symbol_s};
            if (len_r == MAX_LEN) begin
              too_long_r <= 1'b1;
            end else begin
              len_r <= len_r + 3'd1;
            end
          end else if (tick_r && (dur_r != DUR_MAX)) begin
            dur_r <= dur_r + 10'd1;
          end
        end
        ST_SPACE: begin
          if (rise_s) begin
            state_r <= ST_MARK;
            dur_r   <= '0;
          end else if (gap_r == GAP_W'(LETTER_GAP_TICKS)) begin
            state_r       <= ST_IDLE;
            letter_done_r <= 1'b1;
            done_char_r   <= too_long_r ? ASCII_QMARK : lut_ascii_s;
            code_r        <= '0;
            len_r         <= '0;
            too_long_r    <= 1'b0;
          end else if (tick_r) begin
            gap_r <= gap_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output hold register with valid/ready handshake and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_data_r  <= '0;
      char_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else if (letter_done_r) begin
      if (!char_valid_r || char_ready) begin
        char_data_r  <= done_char_r;
        char_valid_r <= 1'b1;
      end else begin
        overflow_r <= 1'b1;
      end
    end else if (char_valid_r && char_ready) begin
      char_valid_r <= 1'b0;
    end
  end

  assign char_data  = char_data_r;
  assign char_valid = char_valid_r;
  assign key_level  = key_level_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_morse_keyer_decoder.sv
// Self-checking bench for morse_keyer_decoder with short timing parameters.
module tb_morse_keyer_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button_in = 1'b0;
  logic       char_ready = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic       key_level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference Morse alphabet: index 0..25 = 'A'..'Z', 26..35 = '0'..'9'.
  string pats [0:35] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."
  };

  morse_keyer_decoder #(
    .TICK_CYC(10), .DEBOUNCE_CYC(8), .DOT_MAX_TICKS(4), .LETTER_GAP_TICKS(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button_in(button_in), .char_ready(char_ready),
    .char_data(char_data), .char_valid(char_valid), .key_level(key_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_char(input int idx);
    ref_char = (idx < 26) ? (8'h41 + 8'(idx)) : (8'h30 + 8'(idx - 26));
  endfunction

  task automatic hold(input logic v, input int n);
    button_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    button_in = 1'b0;
    char_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_ready();
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
  endtask

  // Keys a pattern: dots 12..25 clk, dashes 50..90 clk, inner gaps 15..50 clk.
  task automatic send_pattern(input string p, input int tail);
    byte c;
    for (int i = 0; i < p.len(); i++) begin
      c = p[i];
      if (c == "-") hold(1'b1, $urandom_range(90, 50));
      else          hold(1'b1, $urandom_range(25, 12));
      if (i < p.len() - 1) hold(1'b0, $urandom_range(50, 15));
    end
    hold(1'b0, tail);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({char_data, char_valid, key_level, overflow} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h v=%b k=%b o=%b, want all 0",
               char_data, char_valid, key_level, overflow);
    end
    do_reset();
    n_checks++;
    if ({char_data, char_valid, key_level, overflow} !== 11'd0) begin
      n_fail++;
      $display("FAIL post_reset_state: got data=%h v=%b k=%b o=%b, want all 0",
               char_data, char_valid, key_level, overflow);
    end
  endtask

  task automatic test_letter_a();
    do_reset();
    hold(1'b1, 20); hold(1'b0, 30); hold(1'b1, 80); hold(1'b0, 200);
    n_checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h41) begin
      n_fail++;
      $display("FAIL letter_a: got v=%b data=%h, want v=1 data=41", char_valid, char_data);
    end
    repeat (50) @(negedge clk);
    n_checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h41) begin
      n_fail++;
      $display("FAIL letter_a_hold: got v=%b data=%h, want v=1 data=41", char_valid, char_data);
    end
    pulse_ready();
    n_checks++;
    if (char_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL letter_a_accept: got v=%b, want 0", char_valid);
    end
    pulse_ready();
    n_checks++;
    if (char_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_when_empty: got v=%b o=%b, want 0 0", char_valid, overflow);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      button_in = ((i / 3) % 2 == 0);
      @(negedge clk);
      n_checks++;
      if (key_level !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_key_level: cycle %0d got %b, want 0", i, key_level);
      end
    end
    hold(1'b0, 200);
    n_checks++;
    if (char_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_no_char: got v=%b, want 0", char_valid);
    end
  endtask

  task automatic test_too_long();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 20);
      hold(1'b0, (i == 5) ? 200 : 30);
    end
    n_checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h3F) begin
      n_fail++;
      $display("FAIL too_long: got v=%b data=%h, want v=1 data=3f", char_valid, char_data);
    end
  endtask

  task automatic test_overflow();
    int  k;
    bit  hit;
    do_reset();
    hold(1'b1, 20); hold(1'b0, 200);   // E
    hold(1'b1, 80); hold(1'b0, 200);   // T, store still full
    n_checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h45 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_drop: got v=%b data=%h o=%b, want 1 45 1",
               char_valid, char_data, overflow);
    end
    repeat (30) @(negedge clk);
    pulse_ready();
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b, want 1", overflow);
    end
    // Slide a one-clock ready pulse until it coincides with T's completion:
    // right after that clock the store must already hold T.
    hit = 1'b0;
    k = 95;
    while (!hit && k < 140) begin
      do_reset();
      hold(1'b1, 20); hold(1'b0, 200);
      hold(1'b1, 80); button_in = 1'b0;
      for (int t = 0; t < 40 && key_level !== 1'b0; t++) @(negedge clk);
      repeat (k) @(negedge clk);
      pulse_ready();
      if (char_valid === 1'b1 && char_data === 8'h54) hit = 1'b1;
      else k++;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL same_clock_accept: got no coincident load, want data=54");
    end
    n_checks++;
    if (overflow !== 1'b0 || char_data !== 8'h54) begin
      n_fail++;
      $display("FAIL same_clock_no_overflow: got data=%h o=%b, want 54 0", char_data, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(1'b1, 20); hold(1'b0, 30); hold(1'b1, 40);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({char_data, char_valid, key_level, overflow} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got data=%h v=%b k=%b o=%b, want all 0",
               char_data, char_valid, key_level, overflow);
    end
    button_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++;
    if (char_valid !== 1'b0 || key_level !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_char: got v=%b k=%b, want 0 0", char_valid, key_level);
    end
  endtask

  task automatic test_long_press();
    do_reset();
    hold(1'b1, 20000); hold(1'b0, 200);
    n_checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h54) begin
      n_fail++;
      $display("FAIL long_press: got v=%b data=%h, want v=1 data=54", char_valid, char_data);
    end
  endtask

  task automatic test_random_letters();
    int idx;
    int t;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      idx = $urandom_range(35, 0);
      send_pattern(pats[idx], 150);
      t = 0;
      while (char_valid !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      n_checks++;
      if (char_valid !== 1'b1 || char_data !== ref_char(idx)) begin
        n_fail++;
        $display("FAIL random_letter %s: got v=%b data=%h, want v=1 data=%h",
                 pats[idx], char_valid, char_data, ref_char(idx));
      end
      pulse_ready();
      n_checks++;
      if (char_valid !== 1'b0 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL random_accept: got v=%b o=%b, want 0 0", char_valid, overflow);
      end
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_glitch();
    test_too_long();
    test_overflow();
    test_reset_mid();
    test_long_press();
    test_random_letters();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
